pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the 5-stage pipelined LEGv8 CPU.
- Drives the enable, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, flag hazards (setflags in EX feeding a B.cond in ID), taken-branch flushes and data-memory wait freezes.
- Keeps stall and flush event counters for performance debug.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared FSM state type and constants for the LEGv8 hazard controller
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALL    = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_t;

  localparam int unsigned ZERO_REG_IDX = 31;

  // Word the IF/ID register loads when flushed (ARMv8 NOP).
  localparam logic [31:0] NOP_INSN = 32'hD503_201F;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/freeze sequencing for the 5-stage LEGv8 pipeline
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = ZERO_REG_IDX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rn_id,
  input  logic [4:0]       rm_id,
  input  logic             use_rn_id,
  input  logic             use_rm_id,
  input  logic             cond_br_id,
  input  logic [4:0]       rd_ex,
  input  logic             memread_ex,
  input  logic             setflags_ex,
  input  logic             br_taken_ex,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  localparam logic [4:0] ZR = ZERO_REG[4:0];

  hz_state_t state_q, state_d;
  logic      lu, fl, hz, hz_live;
  logic      stall_inc, flush_inc;

  assign lu = memread_ex && (rd_ex != ZR) &&
              ((use_rn_id && (rn_id == rd_ex)) || (use_rm_id && (rm_id == rd_ex)));
  assign fl = setflags_ex && cond_br_id;
  assign hz = lu || fl;

  // In STALL the bubble already occupies EX, so the same ID instruction must not stall again.
  assign hz_live = hz && ((state_q == RUN) || (state_q == MEM_WAIT));

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    state_d     = RUN;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      stall_inc = (state_q == MEM_WAIT);
      if (dmem_busy) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        exmem_en = 1'b0;
        state_d  = (state_q == RUN || state_q == STALL || state_q == MEM_WAIT) ? MEM_WAIT : RUN;
      end else if (br_taken_ex) begin
        // MEM_WAIT release falls through here, so a branch held across the freeze still flushes.
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        flush_inc   = 1'b1;
      end else if (hz_live) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        stall_inc   = 1'b1;
        state_d     = STALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .clr_i   (reset),
    .inc_i   (stall_inc),
    .count_o (stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i   (clk),
    .clr_i   (reset),
    .inc_i   (flush_inc),
    .count_o (flush_count)
  );

endmodule
